// File: rtl/bcd_stopwatch_if.sv
// bcd_stopwatch_if: control inputs and BCD/status outputs of the stopwatch
interface bcd_stopwatch_if;
  logic tick_in;
  logic start_stop;
  logic clear;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic running;
  logic rollover;
  modport master (
    output tick_in, start_stop, clear,
    input sec_ones, sec_tens, min_ones, min_tens, running, rollover
  );
  modport slave (
    input tick_in, start_stop, clear,
    output sec_ones, sec_tens, min_ones, min_tens, running, rollover
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: MM:SS BCD stopwatch counting synchronized rising edges of a slow tick
module bcd_stopwatch #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MINUTES = 59
) (
  input logic clkin,
  input logic rst_n,
  bcd_stopwatch_if.slave sw
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [7:0] MAX_BCD = 8'((MAX_MINUTES / 10) * 16 + MAX_MINUTES % 10);
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev, r_rise, r_running, r_rollover;
  logic [3:0] r_so, r_st, r_mo, r_mt;
  logic w_en, w_so_wrap, w_st_wrap, w_min_max;
  // Flops load 1 on reset so a tick already high at release is not counted
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sw.tick_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end
  always_ff @(posedge clkin) begin
    r_state <= !rst_n ? IDLE : w_next;
    r_running <= rst_n && (w_next == RUN);
  end
  always_comb begin
    w_next = sw.clear ? IDLE : !sw.start_stop ? r_state : (r_state == RUN) ? PAUSE : RUN;
  end
  always_comb begin
    w_en = (r_state == RUN) && r_rise;
    w_so_wrap = (r_so == 4'd9);
    w_st_wrap = w_so_wrap && (r_st == 4'd5);
    w_min_max = ({r_mt, r_mo} == MAX_BCD);
  end
  always_ff @(posedge clkin) begin
    if (!rst_n || sw.clear) begin
      r_so <= '0;
      r_st <= '0;
      r_mo <= '0;
      r_mt <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= w_en && w_st_wrap && w_min_max;
      if (w_en) begin
        r_so <= w_so_wrap ? 4'd0 : r_so + 4'd1;
        if (w_so_wrap) r_st <= w_st_wrap ? 4'd0 : r_st + 4'd1;
        if (w_st_wrap) begin
          r_mo <= (w_min_max || r_mo == 4'd9) ? 4'd0 : r_mo + 4'd1;
          r_mt <= w_min_max ? 4'd0 : (r_mo == 4'd9) ? r_mt + 4'd1 : r_mt;
        end
      end
    end
  end
  assign sw.sec_ones = r_so;
  assign sw.sec_tens = r_st;
  assign sw.min_ones = r_mo;
  assign sw.min_tens = r_mt;
  assign sw.running = r_running;
  assign sw.rollover = r_rollover;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: random and directed stimulus on two stopwatches (MAX 59 and MAX 1) against a seconds-count model
module tb_bcd_stopwatch;
  localparam int SYNC = 2;
  logic clkin = 1'b0;
  logic rst_n, tick, ss, clr;
  int n_checks = 0, n_fail = 0;
  int secs[2], st[2], mx[2];
  bit roll[2];
  bit hist[8];
  bit started = 0;
  int ra_cnt = 0, rb_cnt = 0;
  always #5 clkin = ~clkin;
  bcd_stopwatch_if a ();
  bcd_stopwatch_if b ();
  assign a.tick_in = tick;
  assign a.start_stop = ss;
  assign a.clear = clr;
  assign b.tick_in = tick;
  assign b.start_stop = ss;
  assign b.clear = clr;
  bcd_stopwatch #(.SYNC_STAGES(SYNC), .MAX_MINUTES(59)) dut_a (.clkin(clkin), .rst_n(rst_n), .sw(a.slave));
  bcd_stopwatch #(.SYNC_STAGES(SYNC), .MAX_MINUTES(1)) dut_b (.clkin(clkin), .rst_n(rst_n), .sw(b.slave));
  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [17:0] expv(int s, bit r, bit ro);
    int mm, sc;
    mm = s / 60;
    sc = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10), r, ro};
  endfunction
  function automatic int dig(logic [3:0] mt, logic [3:0] mo, logic [3:0] st_, logic [3:0] so);
    return mt * 1000 + mo * 100 + st_ * 10 + so;
  endfunction
  function automatic int in_range(logic [3:0] mt, logic [3:0] mo, logic [3:0] st_, logic [3:0] so);
    return int'(so <= 9 && st_ <= 5 && mo <= 9 && mt <= 9);
  endfunction
  // Model: a count in seconds; a tick counts when the sample SYNC+1 edges back is high and the one before is low
  always @(posedge clkin) begin
    bit rise;
    rise = hist[SYNC] & ~hist[SYNC+1];
    for (int m = 0; m < 2; m++) begin
      if (!rst_n || clr) begin
        secs[m] = 0;
        st[m] = 0;
        roll[m] = 0;
      end else begin
        roll[m] = 0;
        if (st[m] == 1 && rise) begin
          secs[m]++;
          if (secs[m] == (mx[m] + 1) * 60) begin
            secs[m] = 0;
            roll[m] = 1;
          end
        end
        if (ss) st[m] = (st[m] == 1) ? 2 : 1;
      end
    end
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = tick;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] = 1;
      started = 1;
    end
  end
  always @(negedge clkin) begin
    if (started) begin
      check("model_a", int'({a.min_tens, a.min_ones, a.sec_tens, a.sec_ones, a.running, a.rollover}),
            int'(expv(secs[0], st[0] == 1, roll[0])));
      check("model_b", int'({b.min_tens, b.min_ones, b.sec_tens, b.sec_ones, b.running, b.rollover}),
            int'(expv(secs[1], st[1] == 1, roll[1])));
      check("range_a", in_range(a.min_tens, a.min_ones, a.sec_tens, a.sec_ones), 1);
      check("range_b", in_range(b.min_tens, b.min_ones, b.sec_tens, b.sec_ones), 1);
      if (a.rollover) ra_cnt++;
      if (b.rollover) rb_cnt++;
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clkin);
  endtask
  task automatic ticks(int n);
    repeat (n) begin
      tick = 1;
      cyc($urandom_range(2, 5));
      tick = 0;
      cyc($urandom_range(3, 5));
    end
  endtask
  task automatic pulse_ss();
    ss = 1;
    cyc(1);
    ss = 0;
  endtask
  task automatic pulse_clr();
    clr = 1;
    cyc(1);
    clr = 0;
  endtask
  // Raise tick and assert a control pulse on the exact cycle the count enable fires
  task automatic tick_with(bit use_clr);
    tick = 1;
    cyc(SYNC + 1);
    if (use_clr) clr = 1; else ss = 1;
    cyc(1);
    ss = 0;
    clr = 0;
    cyc(1);
    tick = 0;
    cyc(4);
  endtask
  function automatic int da();
    return dig(a.min_tens, a.min_ones, a.sec_tens, a.sec_ones);
  endfunction
  initial begin
    int k;
    mx[0] = 59;
    mx[1] = 1;
    rst_n = 0;
    tick = 1;
    ss = 0;
    clr = 0;
    cyc(3);
    check("rst_digits", da(), 0);
    check("rst_running", int'(a.running), 0);
    check("rst_rollover", int'(a.rollover), 0);
    rst_n = 1;
    pulse_ss();
    cyc(8);
    check("high_at_release", da(), 0);
    check("started", int'(a.running), 1);
    tick = 0;
    cyc(4);
    tick = 1;
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (da() == 0 && k < 20);
    check("latency", k, SYNC + 2);
    check("first_count", da(), 1);
    tick = 0;
    cyc(4);
    ticks(11);
    check("count_12", da(), 12);
    check("run_12", int'(a.running), 1);
    pulse_clr();
    check("clear", da(), 0);
    check("clear_idle", int'(a.running), 0);
    pulse_ss();
    ticks(5);
    check("at_5", da(), 5);
    pulse_ss();
    ticks(3);
    check("paused_5", da(), 5);
    check("paused_run", int'(a.running), 0);
    pulse_ss();
    ticks(2);
    check("resumed_7", da(), 7);
    ticks(2);
    check("at_9", da(), 9);
    tick_with(0);
    check("ss_run_10", da(), 10);
    check("ss_run_pause", int'(a.running), 0);
    tick_with(0);
    check("ss_pause_10", da(), 10);
    check("ss_pause_run", int'(a.running), 1);
    tick_with(1);
    check("clr_tick", da(), 0);
    check("clr_tick_idle", int'(a.running), 0);
    pulse_ss();
    ticks(599);
    check("a_0959", da(), 959);
    check("b_0159", dig(b.min_tens, b.min_ones, b.sec_tens, b.sec_ones), 159);
    ticks(1);
    check("a_1000", da(), 1000);
    check("b_wrap", dig(b.min_tens, b.min_ones, b.sec_tens, b.sec_ones), 0);
    check("b_rolls_5", rb_cnt, 5);
    ticks(2999);
    check("a_5959", da(), 5959);
    check("a_no_roll_yet", ra_cnt, 0);
    ticks(1);
    check("a_wrap", da(), 0);
    check("a_wrap_run", int'(a.running), 1);
    check("a_rolls_1", ra_cnt, 1);
    check("b_rolls_30", rb_cnt, 30);
    ticks(207);
    check("a_0327", da(), 327);
    tick = 1;
    cyc(2);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    check("midrst_digits", da(), 0);
    check("midrst_running", int'(a.running), 0);
    check("midrst_rollover", int'(a.rollover), 0);
    tick = 0;
    cyc(6);
    check("midrst_hold", da(), 0);
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) tick = ~tick;
      ss = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 127) == 0);
      rst_n = ($urandom_range(0, 511) != 0);
      cyc(1);
    end
    rst_n = 1;
    ss = 0;
    clr = 0;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
